// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: bus access size codes, the EBREAK encoding and the
// instruction-fetch state type.
package rv32_pkg;

  localparam logic [1:0]  SIZE_NONE = 2'b00;
  localparam logic [1:0]  SIZE_BYTE = 2'b01;
  localparam logic [1:0]  SIZE_HALF = 2'b10;
  localparam logic [1:0]  SIZE_WORD = 2'b11;

  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_CAPTURE = 3'd1,
    S_VALID   = 3'd2,
    S_HALTED  = 3'd3,
    S_FAULT   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Three-phase instruction fetch unit: address the bus, capture the word, then
// hold it for decode until accepted. Handles redirects, EBREAK halt and faults.
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] bus_addr,
  output logic        bus_rw,
  output logic [1:0]  bus_size,
  input  logic [31:0] bus_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_nxt;
  logic [31:0]  r_instr_pc;
  logic [31:0]  w_instr_pc_nxt;
  logic [1:0]   r_bus_size;
  logic         r_instr_valid;
  logic         r_halted;
  logic         r_fault;

  // Next-state, pc and instruction-latch selection; redirect outranks a transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    if ((r_state != S_FAULT) && redirect) begin
      if (redirect_pc[1:0] != 2'b00) begin
        w_state_nxt = S_FAULT;
      end else begin
        w_pc_nxt    = redirect_pc;
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          w_state_nxt = S_CAPTURE;
        end
        S_CAPTURE: begin
          w_instr_nxt    = bus_data;
          w_instr_pc_nxt = r_pc;
          w_state_nxt    = S_VALID;
        end
        S_VALID: begin
          if (instr_ready) begin
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = (r_instr == EBREAK) ? S_HALTED : S_FETCH;
          end else begin
            w_state_nxt = S_VALID;
          end
        end
        S_HALTED: begin
          w_state_nxt = S_HALTED;
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_FAULT;
        end
      endcase
    end
  end

  // State, pc, instruction latch and registered status/bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_bus_size    <= SIZE_WORD;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_bus_size    <= ((w_state_nxt == S_FETCH) || (w_state_nxt == S_CAPTURE)) ?
                       SIZE_WORD : SIZE_NONE;
      r_instr_valid <= (w_state_nxt == S_VALID);
      r_halted      <= (w_state_nxt == S_HALTED);
      r_fault       <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus_addr    = r_pc;
  assign bus_rw      = 1'b0;
  assign bus_size    = r_bus_size;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// ready/redirect/reset traffic compared every cycle against a behavioural model.
module tb_instruction_fetch;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_data, instr, instr_pc, redirect_pc;
  logic        bus_rw, instr_valid, instr_ready, redirect, halted, fault;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr_2, bus_data_2, instr_2, instr_pc_2;
  logic        bus_rw_2, instr_valid_2, halted_2, fault_2;
  logic [1:0]  bus_size_2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [logic [31:0]];

  logic [31:0] m_pc;
  int          m_wait;
  bit          m_halt, m_fault;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_rw(bus_rw),
    .bus_size(bus_size), .bus_data(bus_data), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted), .fault(fault)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .bus_addr(bus_addr_2), .bus_rw(bus_rw_2),
    .bus_size(bus_size_2), .bus_data(bus_data_2), .instr(instr_2),
    .instr_pc(instr_pc_2), .instr_valid(instr_valid_2), .instr_ready(1'b1),
    .redirect(1'b0), .redirect_pc(32'h0000_0000), .halted(halted_2), .fault(fault_2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Instruction memory: data appears one edge after a word access is sampled.
  always @(posedge clk) begin
    bus_data   <= (bus_size   == SIZE_WORD) ? rom(bus_addr)   : 32'hDEAD_BEEF;
    bus_data_2 <= (bus_size_2 == SIZE_WORD) ? rom(bus_addr_2) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_wait counts edges until the current pc's word is presented.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= 32'h0000_0000;
      m_wait  <= 2;
      m_halt  <= 1'b0;
      m_fault <= 1'b0;
    end else if (!m_fault) begin
      if (redirect) begin
        if (redirect_pc[1:0] != 2'b00) begin
          m_fault <= 1'b1;
        end else begin
          m_pc   <= redirect_pc;
          m_wait <= 2;
          m_halt <= 1'b0;
        end
      end else if (!m_halt) begin
        if (m_wait > 0) begin
          m_wait <= m_wait - 1;
        end else if (instr_ready) begin
          m_halt <= (rom(m_pc) == EBREAK);
          m_pc   <= m_pc + 32'd4;
          m_wait <= 2;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : cmp
    logic ev, fetching;
    if (chk_en && !rst) begin
      ev       = !m_fault && !m_halt && (m_wait == 0);
      fetching = !m_fault && !m_halt && (m_wait > 0);
      chk("m_fault", 32'(fault), 32'(m_fault));
      chk("m_halted", 32'(halted), 32'(m_halt && !m_fault));
      chk("m_valid", 32'(instr_valid), 32'(ev));
      chk("m_bus_rw", 32'(bus_rw), 32'd0);
      chk("m_bus_size", 32'(bus_size), fetching ? 32'd3 : 32'd0);
      if (fetching) chk("m_bus_addr", bus_addr, m_pc);
      if (ev) begin
        chk("m_instr", instr, rom(m_pc));
        chk("m_instr_pc", instr_pc, m_pc);
      end
    end
  end

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!instr_valid && n < 20) begin
      next();
      n++;
    end
    chk(nm, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    mem[32'h0]  = 32'h11;
    mem[32'h4]  = 32'h22;
    mem[32'h8]  = 32'h33;
    mem[32'h3C] = EBREAK;
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) next();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_bus_size", 32'(bus_size), 32'd3);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_addr2", bus_addr_2, 32'hFFFF_FFFC);

    chk_en = 1'b1; instr_ready = 1'b1; rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      next();
      chk("seq_valid", 32'(instr_valid), 32'(k % 3 == 2));
      if (k % 3 == 2) begin
        chk("seq_pc", instr_pc, 32'((k / 3) * 4));
        chk("seq_instr", instr, 32'(32'h11 * (k / 3 + 1)));
      end
      if (k == 2) begin
        chk("wrap_valid", 32'(instr_valid_2), 32'd1);
        chk("wrap_pc0", instr_pc_2, 32'hFFFF_FFFC);
      end
      if (k == 5) begin
        chk("wrap_pc1", instr_pc_2, 32'h0000_0000);
        chk("wrap_instr1", instr_2, 32'h11);
        chk("wrap_flags", {29'd0, bus_rw_2, halted_2, fault_2}, 32'd0);
      end
    end

    instr_ready = 1'b0;
    repeat (5) begin
      next();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h33);
      chk("stall_pc", instr_pc, 32'h8);
      chk("stall_bus_size", 32'(bus_size), 32'd0);
    end
    instr_ready = 1'b1;

    n = 0;
    next();
    while (m_wait != 1 && n < 10) begin next(); n++; end
    chk("cap_reached", 32'(bus_size), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h20;
    next();
    redirect = 1'b0;
    wait_valid("redir_wait");
    chk("redir_pc", instr_pc, 32'h20);
    chk("redir_instr", instr, 32'h5A7A_0020);

    redirect = 1'b1; redirect_pc = 32'h22;
    next();
    redirect = 1'b0;
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_bus", 32'(bus_size), 32'd0);
    chk("fault_valid", 32'(instr_valid), 32'd0);
    repeat (3) begin
      next();
      chk("fault_sticky", 32'(fault), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("fault_clr", 32'(fault), 32'd0);
    next();
    rst = 1'b0;

    instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3C;
    next();
    redirect = 1'b0;
    wait_valid("brk_wait");
    chk("brk_pc", instr_pc, 32'h3C);
    chk("brk_instr", instr, 32'h0010_0073);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    next();
    redirect = 1'b0; instr_ready = 1'b0;
    chk("both_no_halt", 32'(halted), 32'd0);
    wait_valid("both_wait");
    chk("both_pc", instr_pc, 32'h80);

    redirect = 1'b1; redirect_pc = 32'h3C;
    next();
    redirect = 1'b0;
    wait_valid("brk2_wait");
    instr_ready = 1'b1;
    next();
    chk("halt_set", 32'(halted), 32'd1);
    repeat (5) begin
      next();
      chk("halt_bus", 32'(bus_size), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    next();
    redirect = 1'b0;
    chk("resume_halted", 32'(halted), 32'd0);
    chk("resume_addr", bus_addr, 32'h0);
    wait_valid("resume_wait");
    chk("resume_pc", instr_pc, 32'h0);
    chk("resume_instr", instr, 32'h11);

    for (int i = 0; i < 2000; i++) begin
      next();
      rst         = ($urandom_range(0, 149) == 0);
      instr_ready = ($urandom_range(0, 99) < 70);
      redirect    = ($urandom_range(0, 19) == 0);
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                      : 32'($urandom_range(0, 31) * 4);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      redirect_pc = a;
    end
    next();
    rst = 1'b0; redirect = 1'b0;
    repeat (4) next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
